// File: rtl/line_dma_sequencer.sv
// Line DMA sequencer: copies each completed half of a ping-pong video line buffer
// into a frame buffer in memory, one 64-bit read/write beat at a time.
module line_dma_sequencer #(
  parameter int unsigned LINE_WORDS  = 160,
  parameter int unsigned FRAME_LINES = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_enable,
  input  logic [31:0] dma_base,
  input  logic        which_line,
  input  logic        vblank,
  output logic [9:0]  vm_address,
  output logic        vm_bus_enable,
  output logic        vm_rw,
  input  logic        vm_acknowledge,
  input  logic [63:0] vm_read_data,
  output logic [31:0] wm_address,
  output logic        wm_write,
  output logic [63:0] wm_writedata,
  input  logic        wm_waitrequest,
  output logic        dma_active,
  output logic [31:0] frame_counter,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARMED     = 3'd1,
    S_WAIT_LINE = 3'd2,
    S_READ      = 3'd3,
    S_WRITE     = 3'd4,
    S_LINE_DONE = 3'd5
  } state_t;

  localparam logic [8:0]  LAST_WORD   = 9'(LINE_WORDS - 1);
  localparam logic [16:0] LINES_FRAME = 17'(FRAME_LINES);
  localparam logic [31:0] LINE_BYTES  = 32'(LINE_WORDS * 8);

  state_t      state_q, state_d;
  logic        which_line_q, which_line_d;
  logic        vblank_q, vblank_d;
  logic        half_q, half_d;
  logic [8:0]  word_idx_q, word_idx_d;
  logic [15:0] line_idx_q, line_idx_d;
  logic [31:0] line_base_q, line_base_d;
  logic        vm_bus_enable_q, vm_bus_enable_d;
  logic        wm_write_q, wm_write_d;
  logic [31:0] wm_address_q, wm_address_d;
  logic [63:0] wm_writedata_q, wm_writedata_d;
  logic [31:0] frame_counter_q, frame_counter_d;
  logic        overrun_q, overrun_d;
  logic        stop_q, stop_d;

  logic        toggle_s;
  logic        vblank_fall_s;
  logic        vblank_rise_s;
  logic        busy_s;
  logic [16:0] line_next_s;

  assign toggle_s      = which_line ^ which_line_q;
  assign vblank_fall_s = vblank_q & ~vblank;
  assign vblank_rise_s = ~vblank_q & vblank;
  assign busy_s        = (state_q == S_READ) || (state_q == S_WRITE) || (state_q == S_LINE_DONE);
  assign line_next_s   = {1'b0, line_idx_q} + 17'd1;

  assign vm_address    = {half_q, word_idx_q};
  assign vm_bus_enable = vm_bus_enable_q;
  assign vm_rw         = 1'b1;
  assign wm_address    = wm_address_q;
  assign wm_write      = wm_write_q;
  assign wm_writedata  = wm_writedata_q;
  assign dma_active    = (state_q != S_IDLE);
  assign frame_counter = frame_counter_q;
  assign overrun       = overrun_q;

  // Next-state and datapath decode for the sequencer FSM.
  always_comb begin
    state_d         = state_q;
    which_line_d    = which_line;
    vblank_d        = vblank;
    half_d          = half_q;
    word_idx_d      = word_idx_q;
    line_idx_d      = line_idx_q;
    line_base_d     = line_base_q;
    vm_bus_enable_d = vm_bus_enable_q;
    wm_write_d      = wm_write_q;
    wm_address_d    = wm_address_q;
    wm_writedata_d  = wm_writedata_q;
    frame_counter_d = frame_counter_q;

    // A line finishing while the previous one is still moving is lost, not queued.
    if (busy_s && toggle_s) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    // A disable during a transfer is remembered and honoured at the line boundary.
    if (busy_s && !dma_enable) begin
      stop_d = 1'b1;
    end else begin
      stop_d = stop_q;
    end

    case (state_q)
      S_IDLE: begin
        if (dma_enable) begin
          overrun_d = 1'b0;
          state_d   = S_ARMED;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_ARMED: begin
        if (!dma_enable) begin
          state_d = S_IDLE;
        end else if (vblank_fall_s) begin
          line_base_d = dma_base;
          line_idx_d  = 16'd0;
          word_idx_d  = 9'd0;
          state_d     = S_WAIT_LINE;
        end else begin
          state_d     = S_ARMED;
        end
      end
      S_WAIT_LINE: begin
        if (!dma_enable) begin
          state_d = S_IDLE;
        end else if (vblank_rise_s && (line_idx_q != 16'd0)) begin
          overrun_d = 1'b1;
          state_d   = S_ARMED;
        end else if (toggle_s) begin
          half_d          = which_line_q;
          word_idx_d      = 9'd0;
          vm_bus_enable_d = 1'b1;
          stop_d          = 1'b0;
          state_d         = S_READ;
        end else begin
          state_d = S_WAIT_LINE;
        end
      end
      S_READ: begin
        if (vm_acknowledge) begin
          vm_bus_enable_d = 1'b0;
          wm_write_d      = 1'b1;
          wm_address_d    = line_base_q + {20'd0, word_idx_q, 3'b000};
          wm_writedata_d  = vm_read_data;
          state_d         = S_WRITE;
        end else begin
          state_d = S_READ;
        end
      end
      S_WRITE: begin
        if (!wm_waitrequest) begin
          wm_write_d = 1'b0;
          if (word_idx_q == LAST_WORD) begin
            state_d = S_LINE_DONE;
          end else begin
            word_idx_d      = word_idx_q + 9'd1;
            vm_bus_enable_d = 1'b1;
            state_d         = S_READ;
          end
        end else begin
          state_d = S_WRITE;
        end
      end
      S_LINE_DONE: begin
        line_idx_d  = line_next_s[15:0];
        line_base_d = line_base_q + LINE_BYTES;
        stop_d      = 1'b0;
        if (line_next_s == LINES_FRAME) begin
          frame_counter_d = frame_counter_q + 32'd1;
          state_d = (dma_enable && !stop_q) ? S_ARMED : S_IDLE;
        end else begin
          state_d = (dma_enable && !stop_q) ? S_WAIT_LINE : S_IDLE;
        end
      end
      default: begin
        vm_bus_enable_d = 1'b0;
        wm_write_d      = 1'b0;
        state_d         = S_IDLE;
      end
    endcase
  end

  // State, edge-detect and output registers; reset drops both bus requests at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      which_line_q    <= 1'b0;
      vblank_q        <= 1'b0;
      half_q          <= 1'b0;
      word_idx_q      <= 9'd0;
      line_idx_q      <= 16'd0;
      line_base_q     <= 32'd0;
      vm_bus_enable_q <= 1'b0;
      wm_write_q      <= 1'b0;
      wm_address_q    <= 32'd0;
      wm_writedata_q  <= 64'd0;
      frame_counter_q <= 32'd0;
      overrun_q       <= 1'b0;
      stop_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      which_line_q    <= which_line_d;
      vblank_q        <= vblank_d;
      half_q          <= half_d;
      word_idx_q      <= word_idx_d;
      line_idx_q      <= line_idx_d;
      line_base_q     <= line_base_d;
      vm_bus_enable_q <= vm_bus_enable_d;
      wm_write_q      <= wm_write_d;
      wm_address_q    <= wm_address_d;
      wm_writedata_q  <= wm_writedata_d;
      frame_counter_q <= frame_counter_d;
      overrun_q       <= overrun_d;
      stop_q          <= stop_d;
    end
  end

endmodule

// File: tb/tb_line_dma_sequencer.sv
// Directed bench for line_dma_sequencer (4 words/line, 2 lines/frame) with a
// frame-buffer write model and per-cycle bus checks.
module tb_line_dma_sequencer;
  localparam int LW = 4;
  localparam int FL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        dma_enable;
  logic [31:0] dma_base;
  logic        which_line;
  logic        vblank;
  logic [9:0]  vm_address;
  logic        vm_bus_enable;
  logic        vm_rw;
  logic        vm_acknowledge;
  logic [63:0] vm_read_data;
  logic [31:0] wm_address;
  logic        wm_write;
  logic [63:0] wm_writedata;
  logic        wm_waitrequest;
  logic        dma_active;
  logic [31:0] frame_counter;
  logic        overrun;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_addr[$];
  logic [63:0] exp_data[$];
  logic [31:0] log_addr[$];
  logic [63:0] log_data[$];
  logic stall_en, stall_force;
  int   stall_cnt, stall_seen;

  always #5 clk = ~clk;

  line_dma_sequencer #(.LINE_WORDS(LW), .FRAME_LINES(FL)) dut (
    .clk(clk), .rst(rst), .dma_enable(dma_enable), .dma_base(dma_base),
    .which_line(which_line), .vblank(vblank), .vm_address(vm_address),
    .vm_bus_enable(vm_bus_enable), .vm_rw(vm_rw), .vm_acknowledge(vm_acknowledge),
    .vm_read_data(vm_read_data), .wm_address(wm_address), .wm_write(wm_write),
    .wm_writedata(wm_writedata), .wm_waitrequest(wm_waitrequest),
    .dma_active(dma_active), .frame_counter(frame_counter), .overrun(overrun)
  );

  // Line-buffer contents: each word encodes its own {half, word} address.
  function automatic logic [63:0] buf_word(input logic [9:0] a);
    return {6'd0, a, 16'hBEEF, 22'd0, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Expected memory image of one line: consecutive 8-byte words after the line start.
  task automatic expect_line(input logic [31:0] base, input int line, input logic half);
    for (int w = 0; w < LW; w++) begin
      exp_addr.push_back(base + 32'((line * LW + w) * 8));
      exp_data.push_back(buf_word({half, 9'(w)}));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_addr.size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    chk("drain", 64'(exp_addr.size()), 64'd0);
    exp_addr.delete();
    exp_data.delete();
    tick(3);
  endtask

  task automatic serve_line(input logic [31:0] base, input int line);
    expect_line(base, line, which_line);
    which_line = ~which_line;
    drain();
  endtask

  task automatic vfall();
    vblank = 1'b1;
    tick(2);
    vblank = 1'b0;
    tick(2);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_vm_en"}, vm_bus_enable, 1'b0);
    chk({tag, "_wm_wr"}, wm_write, 1'b0);
    chk({tag, "_vm_rw"}, vm_rw, 1'b1);
    chk({tag, "_vm_addr"}, vm_address, 10'd0);
    chk({tag, "_wm_addr"}, wm_address, 32'd0);
    chk({tag, "_wm_data"}, wm_writedata, 64'd0);
    chk({tag, "_active"}, dma_active, 1'b0);
    chk({tag, "_frames"}, frame_counter, 32'd0);
    chk({tag, "_overrun"}, overrun, 1'b0);
  endtask

  // Line-buffer read port: acknowledges one cycle after it sees a request.
  initial begin : vm_responder
    logic seen;
    seen = 1'b0;
    vm_acknowledge = 1'b0;
    vm_read_data = 64'd0;
    forever begin
      @(posedge clk);
      #1;
      if (vm_bus_enable && !vm_acknowledge && seen) begin
        vm_acknowledge = 1'b1;
        vm_read_data = buf_word(vm_address);
        seen = 1'b0;
      end else begin
        vm_acknowledge = 1'b0;
        seen = vm_bus_enable;
      end
    end
  end

  // Memory write port: optional 5-cycle stall on the third beat, or a permanent stall.
  initial begin : wm_responder
    wm_waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_force && wm_write) begin
        wm_waitrequest = 1'b1;
      end else if (stall_en && wm_write && log_addr.size() == 2 && stall_cnt < 5) begin
        wm_waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        wm_waitrequest = 1'b0;
      end
    end
  end

  // Per-cycle compare against the write model and the bus rules.
  initial begin : compare
    logic        prev_stall;
    logic [31:0] prev_addr, ea;
    logic [63:0] prev_data, ed;
    int cyc, last_beat;
    prev_stall = 1'b0;
    prev_addr = 32'd0;
    prev_data = 64'd0;
    cyc = 0;
    last_beat = -100;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        prev_stall = 1'b0;
        last_beat = -100;
      end else begin
        chk("vm_rw", vm_rw, 1'b1);
        chk("exclusive", vm_bus_enable & wm_write, 1'b0);
        if (prev_stall) begin
          chk("hold_wr", wm_write, 1'b1);
          chk("hold_addr", wm_address, prev_addr);
          chk("hold_data", wm_writedata, prev_data);
        end
        if (wm_write && wm_waitrequest) stall_seen++;
        if (wm_write && !wm_waitrequest) begin
          chk("beat_gap", 64'(cyc - last_beat >= 3), 64'd1);
          last_beat = cyc;
          log_addr.push_back(wm_address);
          log_data.push_back(wm_writedata);
          if (exp_addr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", wm_address, wm_writedata);
          end else begin
            ea = exp_addr.pop_front();
            ed = exp_data.pop_front();
            chk("wr_addr", wm_address, ea);
            chk("wr_data", wm_writedata, ed);
          end
        end
        prev_stall = wm_write & wm_waitrequest;
        prev_addr = wm_address;
        prev_data = wm_writedata;
      end
    end
  end

  initial begin : main
    int n;
    rst = 1'b0; dma_enable = 1'b0; dma_base = 32'd0; which_line = 1'b0; vblank = 1'b0;
    stall_en = 1'b0; stall_force = 1'b0; stall_cnt = 0; stall_seen = 0;
    tick(3);
    reset_checks("rst");
    rst = 1'b1;
    tick(2);
    chk("idle_active", dma_active, 1'b0);

    // Nominal frame at 0x1000.
    dma_enable = 1'b1; dma_base = 32'h1000;
    tick(2);
    chk("armed_active", dma_active, 1'b1);
    vfall();
    serve_line(32'h1000, 0);
    serve_line(32'h1000, 1);
    chk("nom_frames", frame_counter, 32'd1);
    chk("nom_overrun", overrun, 1'b0);
    chk("nom_active", dma_active, 1'b1);
    chk("nom_count", 64'(log_addr.size()), 64'd8);
    chk("nom_addr0", log_addr[0], 32'h1000);
    chk("nom_addr7", log_addr[7], 32'h1038);
    chk("nom_data0", log_data[0], 64'h0000_BEEF_0000_0000);
    chk("nom_data4", log_data[4], 64'h0200_BEEF_0000_0200);

    // Backpressure: five wait cycles on beat 2.
    log_addr.delete(); log_data.delete();
    dma_base = 32'h2000; stall_en = 1'b1; stall_cnt = 0; stall_seen = 0;
    vfall();
    serve_line(32'h2000, 0);
    stall_en = 1'b0;
    serve_line(32'h2000, 1);
    chk("bp_stalls", 64'(stall_seen), 64'd5);
    chk("bp_count", 64'(log_addr.size()), 64'd8);
    chk("bp_addr2", log_addr[2], 32'h2010);
    chk("bp_frames", frame_counter, 32'd2);

    // Overrun: a second toggle during line 0 is dropped.
    log_addr.delete(); log_data.delete();
    dma_base = 32'h1000;
    vfall();
    expect_line(32'h1000, 0, which_line);
    which_line = ~which_line;
    tick(4);
    which_line = ~which_line;
    drain();
    chk("ovr_flag", overrun, 1'b1);
    chk("ovr_count", 64'(log_addr.size()), 64'd4);
    serve_line(32'h1000, 1);
    chk("ovr_addr4", log_addr[4], 32'h1020);
    chk("ovr_data4", log_data[4], 64'h0000_BEEF_0000_0000);
    chk("ovr_sticky", overrun, 1'b1);
    chk("ovr_frames", frame_counter, 32'd3);

    // Disable during beat 1 of line 0: the line finishes, then idle.
    log_addr.delete(); log_data.delete();
    dma_base = 32'h3000;
    vfall();
    expect_line(32'h3000, 0, which_line);
    which_line = ~which_line;
    n = 0;
    while (log_addr.size() < 1 && n < 100) begin tick(1); n++; end
    chk("dis_beat0", 64'(log_addr.size()), 64'd1);
    dma_enable = 1'b0;
    drain();
    chk("dis_count", 64'(log_addr.size()), 64'd4);
    chk("dis_active", dma_active, 1'b0);
    chk("dis_frames", frame_counter, 32'd3);
    which_line = ~which_line;
    tick(20);
    chk("dis_no_more", 64'(log_addr.size()), 64'd4);

    // Short frame: vblank rises after one line; next frame restarts at base.
    dma_enable = 1'b1; dma_base = 32'h4000;
    tick(2);
    chk("sf_ovr_clear", overrun, 1'b0);
    vfall();
    serve_line(32'h4000, 0);
    vblank = 1'b1;
    tick(2);
    chk("sf_overrun", overrun, 1'b1);
    chk("sf_active", dma_active, 1'b1);
    chk("sf_frames", frame_counter, 32'd3);
    log_addr.delete(); log_data.delete();
    vblank = 1'b0;
    tick(2);
    serve_line(32'h4000, 0);
    serve_line(32'h4000, 1);
    chk("sf_restart", log_addr[0], 32'h4000);
    chk("sf_frames2", frame_counter, 32'd4);

    // Asynchronous reset while a write is stalled.
    dma_base = 32'h5000; stall_force = 1'b1;
    vfall();
    which_line = ~which_line;
    n = 0;
    while (!wm_write && n < 50) begin tick(1); n++; end
    chk("ar_stalled", wm_write, 1'b1);
    tick(1);
    chk("ar_still", wm_write, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    reset_checks("arst");
    tick(2);
    stall_force = 1'b0;
    rst = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
